// File: rtl/softmax_frame_sequencer.sv
// Buffers one frame of elements while tracking its maximum, then replays
// the frame twice (sum pass, normalise pass) to a softmax datapath.
// Ports: clock_i/reset_n_i; start_i,len_i,abort_i frame control;
//   data_i/data_valid_i/data_ready_o load side;
//   data_o,max_o,data_valid_o/ready_i,pass_o,last_o replay side;
//   busy_o level, done_o end-of-frame pulse, err_o bad-length pulse.
module softmax_frame_sequencer #(
  parameter int DATA_SIZE = 32,
  parameter int MAX_LEN   = 16,
  parameter int LEN_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 start_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 abort_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 data_ready_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic [DATA_SIZE-1:0] max_o,
  output logic                 data_valid_o,
  input  logic                 ready_i,
  output logic                 pass_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE, LOAD, PASS0, PASS1
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]     rd_idx_q, rd_idx_d;
  logic [DATA_SIZE-1:0] max_q, max_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic ready_q, ready_d;
  logic valid_q, valid_d;
  logic pass_q, pass_d;
  logic last_q, last_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic [DATA_SIZE-1:0] mem_q [MAX_LEN];

  logic             wr_fire;
  logic             rd_fire;
  logic [LEN_W-1:0] nxt_idx;
  logic [LEN_W-1:0] len_m1;

  assign wr_fire = ready_q & data_valid_i;
  assign rd_fire = valid_q & ready_i;
  assign nxt_idx = rd_idx_q + ONE;
  assign len_m1  = len_q - ONE;

  // Sign-magnitude ordering; any pair of zeros compares equal so
  // a held -0 is not displaced by +0 (and vice versa).
  function automatic logic gt(
    input logic [DATA_SIZE-1:0] a,
    input logic [DATA_SIZE-1:0] b
  );
    logic [DATA_SIZE-2:0] ma;
    logic [DATA_SIZE-2:0] mb;
    ma = a[DATA_SIZE-2:0];
    mb = b[DATA_SIZE-2:0];
    if (ma == '0 && mb == '0) return 1'b0;
    if (a[DATA_SIZE-1] != b[DATA_SIZE-1])
      return ~a[DATA_SIZE-1];
    if (!a[DATA_SIZE-1]) return ma > mb;
    return ma < mb;
  endfunction

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_cnt_d = wr_cnt_q;
    rd_idx_d = rd_idx_q;
    max_d    = max_q;
    data_d   = data_q;
    ready_d  = ready_q;
    valid_d  = valid_q;
    pass_d   = pass_q;
    last_d   = last_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
      ready_d = 1'b0;
      valid_d = 1'b0;
      pass_d  = 1'b0;
      last_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0 &&
                len_i <= LEN_W'(MAX_LEN)) begin
              len_d    = len_i;
              wr_cnt_d = '0;
              state_d  = LOAD;
              ready_d  = 1'b1;
              busy_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + ONE;
            if (wr_cnt_q == '0 || gt(data_i, max_q))
              max_d = data_i;
            if (wr_cnt_q == len_m1) begin
              state_d  = PASS0;
              ready_d  = 1'b0;
              valid_d  = 1'b1;
              pass_d   = 1'b0;
              rd_idx_d = '0;
              last_d   = (len_q == ONE);
              // A one-element frame is still being written this cycle.
              data_d   = (wr_cnt_q == '0) ? data_i : mem_q[0];
            end
          end
        end
        PASS0, PASS1: begin
          if (rd_fire) begin
            if (last_q) begin
              if (state_q == PASS0) begin
                state_d  = PASS1;
                pass_d   = 1'b1;
                rd_idx_d = '0;
                data_d   = mem_q[0];
                last_d   = (len_q == ONE);
              end else begin
                state_d = IDLE;
                valid_d = 1'b0;
                pass_d  = 1'b0;
                last_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              rd_idx_d = nxt_idx;
              data_d   = mem_q[nxt_idx[AW-1:0]];
              last_d   = (nxt_idx == len_m1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      max_q    <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      pass_q   <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_cnt_q <= wr_cnt_d;
      rd_idx_q <= rd_idx_d;
      max_q    <= max_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      pass_q   <= pass_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_fire && !abort_i)
      mem_q[wr_cnt_q[AW-1:0]] <= data_i;
  end

  assign data_ready_o = ready_q;
  assign data_o       = data_q;
  assign max_o        = max_q;
  assign data_valid_o = valid_q;
  assign pass_o       = pass_q;
  assign last_o       = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_softmax_frame_sequencer.sv
// Directed bench for softmax_frame_sequencer.
// Ports: none; drives the DUT and prints one summary line.
module tb_softmax_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic        abort = 1'b0;
  logic [31:0] din = '0;
  logic        din_v = 1'b0;
  logic        din_r;
  logic [31:0] dout;
  logic [31:0] mx;
  logic        dout_v;
  logic        rdy = 1'b0;
  logic        pass;
  logic        last;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] vec [16];

  always #5 clk = ~clk;

  softmax_frame_sequencer dut (
    .clock_i     (clk),
    .reset_n_i   (rst_n),
    .start_i     (start),
    .len_i       (len),
    .abort_i     (abort),
    .data_i      (din),
    .data_valid_i(din_v),
    .data_ready_o(din_r),
    .data_o      (dout),
    .max_o       (mx),
    .data_valid_o(dout_v),
    .ready_i     (rdy),
    .pass_o      (pass),
    .last_o      (last),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int n);
    start = 1'b1;
    len   = 5'(n);
    tick();
    start = 1'b0;
    chk("load_ready", 32'(din_r), 32'd1);
    chk("load_busy", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      din   = vec[i];
      din_v = 1'b1;
      tick();
    end
    din_v = 1'b0;
    chk("load_ready_drop", 32'(din_r), 32'd0);
  endtask

  // hold bit c set -> ready_i low on output cycle c
  task automatic drain(input int n, input logic [15:0] hold);
    int k;
    int c;
    int vcyc;
    k = 0;
    c = 0;
    vcyc = 0;
    while (k < 2 * n && c < 4 * n + 20) begin
      rdy = (c < 16) ? ~hold[c] : 1'b1;
      chk("out_valid", 32'(dout_v), 32'd1);
      chk("out_data", dout, vec[k % n]);
      chk("out_pass", 32'(pass), 32'(k >= n));
      chk("out_last", 32'(last), 32'((k % n) == n - 1));
      chk("out_done_early", 32'(done), 32'd0);
      if (dout_v) vcyc++;
      if (rdy) k++;
      c++;
      tick();
    end
    rdy = 1'b0;
    chk("drain_budget", 32'(k), 32'(2 * n));
    chk("out_cycles", 32'(vcyc),
        32'(2 * n + $countones(hold)));
    chk("done_pulse", 32'(done), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(dout_v), 32'd0);
    tick();
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(dout_v), 32'd0);
    chk("rst_ready", 32'(din_r), 32'd0);
    chk("rst_max", mx, 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_flags",
        {27'd0, pass, last, busy, done, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    vec[0] = 32'h3F800000;
    vec[1] = 32'h40000000;
    vec[2] = 32'hBF800000;
    load(3);
    chk("max_basic", mx, 32'h40000000);
    drain(3, 16'h0);

    vec[0] = 32'hC0400000;
    vec[1] = 32'hBF800000;
    vec[2] = 32'hC0000000;
    load(3);
    chk("max_neg", mx, 32'hBF800000);
    drain(3, 16'h0);

    vec[0] = 32'h80000000;
    vec[1] = 32'h00000000;
    load(2);
    chk("max_zero", mx, 32'h80000000);
    drain(2, 16'h0);
    tick();
    chk("max_hold", mx, 32'h80000000);

    for (int b = 0; b < 2; b++) begin
      start = 1'b1;
      len   = (b == 0) ? 5'd0 : 5'd17;
      tick();
      start = 1'b0;
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      tick();
      chk("err_clear", 32'(err), 32'd0);
      chk("err_idle", 32'(din_r), 32'd0);
    end

    vec[0] = 32'h00000001;
    vec[1] = 32'h00000005;
    vec[2] = 32'h00000003;
    vec[3] = 32'h00000002;
    load(4);
    chk("max_bp", mx, 32'h00000005);
    drain(4, 16'b0110);

    start = 1'b1;
    len   = 5'd4;
    tick();
    start = 1'b0;
    vec[0] = 32'h40400000;
    vec[1] = 32'h3F800000;
    for (int i = 0; i < 2; i++) begin
      din   = vec[i];
      din_v = 1'b1;
      tick();
    end
    abort = 1'b1;
    start = 1'b1;
    din   = 32'h41000000;
    tick();
    abort = 1'b0;
    start = 1'b0;
    din_v = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(din_r), 32'd0);
    chk("abort_valid", 32'(dout_v), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_max", mx, 32'h40400000);
    tick();
    chk("abort_stay", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++)
      vec[i] = 32'h3F800000 + 32'(i * 16'h100);
    vec[7] = 32'hC1000000;
    load(16);
    chk("max_full", mx, 32'h3F800F00);
    drain(16, 16'h0);

    vec[0] = 32'h11111111;
    vec[1] = 32'h22222222;
    load(2);
    rdy = 1'b1;
    tick();
    tick();
    chk("p1_pass", 32'(pass), 32'd1);
    chk("p1_data", dout, 32'h11111111);
    rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dout_v), 32'd0);
    chk("mid_rst_data", dout, 32'd0);
    chk("mid_rst_max", mx, 32'd0);
    chk("mid_rst_flags",
        {27'd0, pass, last, busy, done, err}, 32'd0);
    tick();
    rst_n = 1'b1;
    din   = 32'h12345678;
    din_v = 1'b1;
    tick();
    tick();
    din_v = 1'b0;
    chk("post_rst_ready", 32'(din_r), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    vec[0] = 32'hC2000000;
    load(1);
    chk("max_one", mx, 32'hC2000000);
    drain(1, 16'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
